// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: sequences an external loadable up-counter and flags its terminal count.
// Optional completed-interval counter output period_cnt is enabled by defining INTERVAL_TIMER_PERIOD_CNT_EN.
module interval_timer_ctrl #(
    parameter int WIDTH    = 5,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_start,
    input  logic [WIDTH-1:0] cfg_end,
    input  logic             cfg_periodic,
    input  logic             start,
    input  logic             stop,
    output logic             cnt_load,
    output logic             cnt_enab,
    output logic [WIDTH-1:0] cnt_init,
    input  logic [WIDTH-1:0] cnt_val,
    output logic             busy,
    output logic             done,
    output logic             irq,
    input  logic             irq_clr
`ifdef INTERVAL_TIMER_PERIOD_CNT_EN
    ,
    output logic [7:0]       period_cnt
`endif
);

    // state | meaning
    // IDLE  | waiting for start, configuration accepted
    // LOAD  | one-cycle preset strobe to the counter
    // RUN   | prescaled counting until terminal value
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] end_q;
    logic             periodic_q;
    logic [PS_W-1:0]  ps_q;
    logic             done_q;
    logic             irq_q;
    logic             cfg_fire;
    logic             at_end;
    logic             done_nx;

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        cfg_fire = cfg_valid && (state == IDLE);
        at_end   = (cnt_val == end_q);
        case (state)
            IDLE: begin
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                state_nx = stop ? IDLE : RUN;
            end
            RUN: begin
                // an abort wins over a terminal count seen in the same cycle
                if (stop) begin
                    state_nx = IDLE;
                end else if (at_end) begin
                    done_nx  = 1'b1;
                    state_nx = periodic_q ? LOAD : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign cnt_load  = (state == LOAD);
    assign cnt_init  = start_q;
    assign cnt_enab  = (state == RUN) && (ps_q == PS_MAX) && !at_end;
    assign done      = done_q;
    assign irq       = irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            start_q    <= '0;
            end_q      <= '0;
            periodic_q <= 1'b0;
            ps_q       <= '0;
            done_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= done_nx;
            if (cfg_fire) begin
                start_q    <= cfg_start;
                end_q      <= cfg_end;
                periodic_q <= cfg_periodic;
            end
            if (state == RUN) begin
                ps_q <= (ps_q == PS_MAX) ? '0 : ps_q + PS_W'(1);
            end else begin
                ps_q <= '0;
            end
            if (done_nx) begin
                irq_q <= 1'b1;
            end else if (irq_clr) begin
                irq_q <= 1'b0;
            end
        end
    end

`ifdef INTERVAL_TIMER_PERIOD_CNT_EN
    logic start_fire;

    assign start_fire = start && (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt <= 8'd0;
        end else if (start_fire) begin
            period_cnt <= 8'd0;
        end else if (done_nx && (period_cnt != 8'hFF)) begin
            period_cnt <= period_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Randomized scoreboard bench for interval_timer_ctrl with a behavioural counter and timing model.
module tb_interval_timer_ctrl;
    localparam int W      = 5;
    localparam int P      = 4;
    localparam int MAXC   = 40000;
    localparam int NTRIAL = 40;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [W-1:0] cfg_start = '0;
    logic [W-1:0] cfg_end = '0;
    logic         cfg_periodic = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         cnt_load;
    logic         cnt_enab;
    logic [W-1:0] cnt_init;
    logic [W-1:0] cnt_val;
    logic         busy;
    logic         done;
    logic         irq;
    logic         irq_clr = 1'b0;
`ifdef INTERVAL_TIMER_PERIOD_CNT_EN
    logic [7:0]   period_cnt;
`endif

    interval_timer_ctrl #(.WIDTH(W), .PRESCALE(P)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_periodic(cfg_periodic),
        .start(start), .stop(stop),
        .cnt_load(cnt_load), .cnt_enab(cnt_enab), .cnt_init(cnt_init), .cnt_val(cnt_val),
        .busy(busy), .done(done), .irq(irq), .irq_clr(irq_clr)
`ifdef INTERVAL_TIMER_PERIOD_CNT_EN
        , .period_cnt(period_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural loadable up-counter that the controller drives
    always @(posedge clk) begin
        if (rst) cnt_val <= '0;
        else if (cnt_load) cnt_val <= cnt_init;
        else if (cnt_enab) cnt_val <= cnt_val + 1'b1;
    end

    bit exp_busy  [MAXC];
    bit exp_load  [MAXC];
    bit exp_done  [MAXC];
    bit clr_at    [MAXC];
    bit clr_force [MAXC];
    bit start_at  [MAXC];
    int exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    logic [W-1:0] cur_s = '0;
    logic [W-1:0] cur_e = '0;
    bit irq_ref = 1'b0;
    int pc_ref = 0;

    function void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        int c;
        c = cyc;
        if (mon_en && c > 0) begin
            if (exp_done[c]) irq_ref = 1'b1;
            else if (clr_at[c-1]) irq_ref = 1'b0;
            if (start_at[c-1]) pc_ref = 0;
            else if (exp_done[c] && pc_ref < 255) pc_ref++;
            chk("busy", busy, exp_busy[c]);
            chk("cfg_ready", cfg_ready, !exp_busy[c]);
            chk("cnt_load", cnt_load, exp_load[c]);
            if (cnt_load) chk("cnt_init", cnt_init, cur_s);
            chk("load_enab_excl", cnt_load && cnt_enab, 0);
            chk("no_overshoot", cnt_enab && (cnt_val == cur_e), 0);
            chk("irq", irq, irq_ref);
`ifdef INTERVAL_TIMER_PERIOD_CNT_EN
            chk("period_cnt", period_cnt, pc_ref);
`endif
            while (exp_q.size() > 0 && exp_q[0] < c) chk("done_missed", -1, exp_q.pop_front());
            if (done) begin
                if (exp_q.size() == 0) chk("done_unexpected", c, -1);
                else chk("done_cycle", c, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (mon_en) begin
            irq_clr = clr_force[cyc] || ($urandom_range(0, 15) == 0);
            clr_at[cyc] = irq_clr;
        end else begin
            irq_clr = 1'b0;
        end
    endtask

    task automatic run_trial(input int tr);
        int s, e, per, do_stop, ts, diff, len, plen, t0, d0, d, endc;
        bit split;
        s = $urandom_range(0, 31);
        e = $urandom_range(0, 31);
        per = $urandom_range(0, 1);
        split = (tr > 2) && ($urandom_range(0, 1) == 1);
        if (tr == 0) begin s = 30; e = 2;  per = 1; end
        if (tr == 1) begin s = 5;  e = 5;  per = 0; end
        if (tr == 2) begin s = 10; e = 14; per = 0; end
        cfg_start = W'(s);
        cfg_end = W'(e);
        cfg_periodic = per[0];
        cfg_valid = 1'b1;
        if (split) begin
            step();
            cfg_valid = 1'b0;
            cfg_start = W'($urandom_range(0, 31));
            cfg_end = W'($urandom_range(0, 31));
        end
        start = 1'b1;
        t0 = cyc;
        start_at[t0] = 1'b1;
        cur_s = W'(s);
        cur_e = W'(e);
        diff = (e - s + 32) % 32;
        len = diff * P;
        plen = 2 + len;
        d0 = t0 + 3 + len;
        if (per != 0) begin
            do_stop = 1;
            ts = (tr == 0) ? d0 + plen : t0 + 1 + $urandom_range(0, 3 * plen);
            endc = ts + 1;
        end else begin
            do_stop = (tr == 1) ? 0 : ((tr == 2) ? 1 : $urandom_range(0, 1));
            ts = (tr == 2) ? d0 - 1 : t0 + 1 + $urandom_range(0, len + 3);
            if (do_stop == 0) ts = -1;
            endc = (do_stop != 0 && ts < d0) ? ts + 1 : d0;
        end
        d = d0;
        while (!(do_stop != 0 && d > ts)) begin
            exp_q.push_back(d);
            exp_done[d] = 1'b1;
            if (per != 0) begin
                exp_load[d] = 1'b1;
                clr_force[d-1] = 1'b1;
            end
            if (per == 0) break;
            d += plen;
        end
        exp_load[t0+1] = 1'b1;
        for (int k = t0 + 1; k < endc; k++) exp_busy[k] = 1'b1;
        while (cyc < endc + 3) begin
            step();
            start = 1'b0;
            cfg_valid = 1'b0;
            stop = (do_stop != 0) && (cyc == ts);
            if (cyc < endc) begin
                start = ($urandom_range(0, 7) == 0);
                cfg_valid = ($urandom_range(0, 3) == 0);
                cfg_start = W'($urandom_range(0, 31));
                cfg_end = W'($urandom_range(0, 31));
                cfg_periodic = $urandom_range(0, 1);
            end
        end
        stop = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_cnt_load", cnt_load, 0);
        chk("rst_cnt_enab", cnt_enab, 0);
        chk("rst_cnt_init", cnt_init, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_irq", irq, 0);
        step();
        mon_en = 1'b1;
        step();
        for (int tr = 0; tr < NTRIAL; tr++) run_trial(tr);
        repeat (4) step();
        chk("queue_empty", exp_q.size(), 0);
        mon_en = 1'b0;

        // reset in the middle of a run, with irq already set
        cfg_start = 5'd7; cfg_end = 5'd7; cfg_periodic = 1'b0; cfg_valid = 1'b1; start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("pre_rst_irq", irq, 1);
        step();
        cfg_start = 5'd0; cfg_end = 5'd20; cfg_valid = 1'b1; start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        repeat (5) step();
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_cfg_ready", cfg_ready, 1);
        chk("midrst_cnt_load", cnt_load, 0);
        chk("midrst_cnt_enab", cnt_enab, 0);
        chk("midrst_cnt_init", cnt_init, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_irq", irq, 0);
`ifdef INTERVAL_TIMER_PERIOD_CNT_EN
        chk("midrst_period_cnt", period_cnt, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: got cycle %0d expected completion before limit", cyc);
        $fatal(1, "timeout");
    end
endmodule
